writeback_ctrl: RTL

WRITEBACK_CTRL -- requirements
Module: writeback_ctrl

---
 rtl/writeback_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/writeback_ctrl.sv
// Register write-back sequencer: accepts one request at a time, waits MEM_WAIT
// cycles for load data, then issues a single register-file write and a done pulse.
module writeback_ctrl #(
   parameter int unsigned MEM_WAIT = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wb_req,
   input  logic [3:0] wb_src,
   input  logic [4:0] wb_dst,
   input  logic       wb_is_load,
   input  logic [1:0] wb_size,
   output logic       wb_busy,
   output logic       wb_done,
   output logic       wb_err,
   output logic [3:0] mem_to_reg_sel,
   output logic       reg_wr,
   output logic [4:0] reg_wr_addr,
   output logic [1:0] ls_ctrl
);

   localparam logic [3:0] C_WAIT_INIT = 4'(MEM_WAIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   state_t     r_state, w_state_next;
   logic [3:0] r_wait_cnt, w_wait_cnt_next;
   logic [3:0] r_sel, w_sel_next;
   logic [4:0] r_addr, w_addr_next;
   logic [1:0] r_ls, w_ls_next;
   logic       r_busy, r_done, r_err, r_reg_wr;
   logic       w_illegal;

   assign w_illegal = (wb_src > 4'd8) || (wb_is_load && (wb_size == 2'b11));

   always_comb begin
      w_state_next    = r_state;
      w_wait_cnt_next = r_wait_cnt;
      w_sel_next      = r_sel;
      w_addr_next     = r_addr;
      w_ls_next       = r_ls;
      case (r_state)
         S_IDLE: begin
            if (wb_req) begin
               if (w_illegal) begin
                  w_state_next = S_ERR;
               end else begin
                  w_sel_next  = wb_src;
                  w_addr_next = wb_dst;
                  w_ls_next   = wb_size;
                  if (wb_is_load) begin
                     w_state_next    = S_WAIT;
                     w_wait_cnt_next = C_WAIT_INIT;
                  end else begin
                     w_state_next = S_WRITE;
                  end
               end
            end
         end
         S_WAIT: begin
            // Counter reads zero in the last wait cycle, so WAIT spans MEM_WAIT cycles.
            if (r_wait_cnt == 4'd0) begin
               w_state_next = S_WRITE;
            end else begin
               w_wait_cnt_next = r_wait_cnt - 4'd1;
            end
         end
         S_WRITE: w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         S_ERR:   w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state itself.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= 4'd0;
         r_sel      <= 4'd0;
         r_addr     <= 5'd0;
         r_ls       <= 2'b00;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_reg_wr   <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_wait_cnt <= w_wait_cnt_next;
         r_sel      <= w_sel_next;
         r_addr     <= w_addr_next;
         r_ls       <= w_ls_next;
         r_busy     <= (w_state_next != S_IDLE);
         r_done     <= (w_state_next == S_DONE);
         r_err      <= (w_state_next == S_ERR);
         r_reg_wr   <= (w_state_next == S_WRITE) && (w_addr_next != 5'd0);
      end
   end

   assign wb_busy        = r_busy;
   assign wb_done        = r_done;
   assign wb_err         = r_err;
   assign reg_wr         = r_reg_wr;
   assign mem_to_reg_sel = r_sel;
   assign reg_wr_addr    = r_addr;
   assign ls_ctrl        = r_ls;

endmodule
